// File: rtl/ucsbece154b_bp_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ucsbece154b_bp_update_ctrl_pkg
// Shared definitions for the branch-predictor update controller:
//   - opcode constants for the control-transfer instruction classes
//   - FSM state encoding for the BTB/PHT write sequencer
//   - small opcode classification helpers
// ---------------------------------------------------------------------------
package ucsbece154b_bp_update_ctrl_pkg;

    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    typedef enum logic [1:0] {
        BPU_IDLE   = 2'd0,
        BPU_BTB_WR = 2'd1,
        BPU_PHT_WR = 2'd2
    } bpu_state_t;

    function automatic logic is_branch_op(input logic [6:0] op);
        return (op == instr_branch_op);
    endfunction

    function automatic logic is_jump_op(input logic [6:0] op);
        return (op == instr_jal_op) || (op == instr_jalr_op);
    endfunction

    function automatic logic is_ctl_op(input logic [6:0] op);
        return is_branch_op(op) || is_jump_op(op);
    endfunction

endpackage

// File: rtl/ucsbece154b_bp_update_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// ucsbece154b_sync_fifo
// Synchronous FIFO with synchronous active-high reset. Pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
// No push/pop bypass: a push is refused while full even if a pop happens in
// the same cycle.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (empties the FIFO)
//   push   in   enqueue wdata (ignored while full)
//   wdata  in   WIDTH-bit entry to enqueue
//   pop    in   dequeue the head entry (ignored while empty)
//   rdata  out  head entry (valid while !empty)
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
// ---------------------------------------------------------------------------
module ucsbece154b_sync_fifo
    import ucsbece154b_bp_update_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; only the pointers define which words are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ucsbece154b_bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// ucsbece154b_bp_update_ctrl
// Buffers execute-stage branch resolutions and drains them into the branch
// predictor's BTB and PHT write ports, one write per cycle (BTB first, then
// PHT). In parallel it flags mispredictions with a one-cycle redirect and an
// optional GHR clear strobe.
//
// State table:
//   state      | meaning
//   BPU_IDLE   | inspect FIFO head; start writes or pop a no-write entry
//   BPU_BTB_WR | BTB write strobe is high for the head entry
//   BPU_PHT_WR | PHT write strobe is high for the head entry; head pops here
//
// Ports:
//   clk, reset_i                 clock, synchronous active-high reset
//   resolve_*_i / resolve_ready_o resolution handshake and payload
//   BTB_we_o, BTBwrite*_o        BTB write port (zero when strobe low)
//   PHTwe_o, PHTwriteaddress_o,
//   PHTincrement_o               PHT write port (zero when strobe low)
//   GHRreset_o                   GHR clear strobe
//   mispredict_o, redirect_pc_o  one-cycle flush request and correct next PC
//   busy_o                       queue non-empty or writes in progress
//   stat_*_o                     saturating event counters, only when the
//                                macro UCSBECE154B_BP_STATS_EN is defined
// ---------------------------------------------------------------------------
module ucsbece154b_bp_update_ctrl
    import ucsbece154b_bp_update_ctrl_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES         = 32,
    parameter int NUM_GHR_BITS            = 5,
    parameter int FIFO_DEPTH              = 4,
    parameter int GHR_RESET_ON_MISPREDICT = 1
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               resolve_valid_i,
    output logic                               resolve_ready_o,
    input  logic [31:0]                        resolve_pc_i,
    input  logic [6:0]                         resolve_op_i,
    input  logic                               resolve_taken_i,
    input  logic [31:0]                        resolve_target_i,
    input  logic                               resolve_predtaken_i,
    input  logic [31:0]                        resolve_predtarget_i,
    input  logic                               resolve_btbhit_i,
    input  logic [NUM_GHR_BITS-1:0]            resolve_phtaddr_i,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               PHTincrement_o,
    output logic                               GHRreset_o,
    output logic                               mispredict_o,
    output logic [31:0]                        redirect_pc_o,
`ifdef UCSBECE154B_BP_STATS_EN
    output logic [31:0]                        stat_resolved_o,
    output logic [31:0]                        stat_mispredict_o,
    output logic [31:0]                        stat_btbwrite_o,
`endif
    output logic                               busy_o
);

    localparam int IDX_W   = $clog2(NUM_BTB_ENTRIES);
    // Only the BTB index bits of the PC are used after queuing, so only those
    // are stored; the full PC is consumed at accept time for redirect_pc_o.
    localparam int ENTRY_W = IDX_W + 32 + 3 + NUM_GHR_BITS;

    // ---------------- classification of the incoming resolution ----------
    logic        in_is_ctl;
    logic        in_is_branch;
    logic        in_taken;
    logic        in_tgt_wrong;
    logic        in_need_btb;
    logic        in_need_pht;
    logic        in_mispredict;
    logic [31:0] in_redirect;
    logic        accept;

    always_comb begin
        in_is_ctl     = is_ctl_op(resolve_op_i);
        in_is_branch  = is_branch_op(resolve_op_i);
        // Jumps are always taken regardless of what the execute stage reports.
        in_taken      = resolve_taken_i || is_jump_op(resolve_op_i);
        in_tgt_wrong  = (resolve_predtarget_i != resolve_target_i);
        in_need_btb   = in_is_ctl && in_taken && (!resolve_btbhit_i || in_tgt_wrong);
        in_need_pht   = in_is_branch;
        in_mispredict = in_is_ctl &&
                        ((in_taken != resolve_predtaken_i) || (in_taken && in_tgt_wrong));
        in_redirect   = in_taken ? resolve_target_i : (resolve_pc_i + 32'd4);
    end

    // ---------------- resolution queue -----------------------------------
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

    logic [IDX_W-1:0]        head_idx;
    logic [31:0]             head_target;
    logic                    head_taken;
    logic                    head_need_btb;
    logic                    head_need_pht;
    logic [NUM_GHR_BITS-1:0] head_phtaddr;

    assign resolve_ready_o = !fifo_full;
    assign accept          = resolve_valid_i && !fifo_full;
    assign entry_in        = {resolve_pc_i[IDX_W+1:2], resolve_target_i, in_taken,
                              in_need_btb, in_need_pht, resolve_phtaddr_i};
    assign {head_idx, head_target, head_taken, head_need_btb, head_need_pht,
            head_phtaddr} = head;

    ucsbece154b_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset_i),
        .push  (accept),
        .wdata (entry_in),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- drain sequencer ------------------------------------
    bpu_state_t state;

    // The head leaves the queue in the last cycle it is needed: in IDLE when
    // it needs no write, otherwise in the cycle of its final write strobe.
    always_comb begin
        fifo_pop = 1'b0;
        unique case (state)
            BPU_IDLE:   fifo_pop = !fifo_empty && !head_need_btb && !head_need_pht;
            BPU_BTB_WR: fifo_pop = !head_need_pht;
            BPU_PHT_WR: fifo_pop = 1'b1;
            default:    fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state             <= BPU_IDLE;
            BTB_we_o          <= 1'b0;
            BTBwriteaddress_o <= '0;
            BTBwritedata_o    <= '0;
            PHTwe_o           <= 1'b0;
            PHTwriteaddress_o <= '0;
            PHTincrement_o    <= 1'b0;
        end else begin
            BTB_we_o          <= 1'b0;
            BTBwriteaddress_o <= '0;
            BTBwritedata_o    <= '0;
            PHTwe_o           <= 1'b0;
            PHTwriteaddress_o <= '0;
            PHTincrement_o    <= 1'b0;
            unique case (state)
                BPU_IDLE: begin
                    if (!fifo_empty && head_need_btb) begin
                        state             <= BPU_BTB_WR;
                        BTB_we_o          <= 1'b1;
                        BTBwriteaddress_o <= head_idx;
                        BTBwritedata_o    <= head_target;
                    end else if (!fifo_empty && head_need_pht) begin
                        state             <= BPU_PHT_WR;
                        PHTwe_o           <= 1'b1;
                        PHTwriteaddress_o <= head_phtaddr;
                        PHTincrement_o    <= head_taken;
                    end
                end
                BPU_BTB_WR: begin
                    if (head_need_pht) begin
                        state             <= BPU_PHT_WR;
                        PHTwe_o           <= 1'b1;
                        PHTwriteaddress_o <= head_phtaddr;
                        PHTincrement_o    <= head_taken;
                    end else begin
                        state <= BPU_IDLE;
                    end
                end
                BPU_PHT_WR: begin
                    state <= BPU_IDLE;
                end
                default: begin
                    state <= BPU_IDLE;
                end
            endcase
        end
    end

    assign busy_o = !fifo_empty || (state != BPU_IDLE);

    // ---------------- mispredict / redirect ------------------------------
    logic mp_now;
    assign mp_now = accept && in_mispredict;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            // When GHR clearing is not tied to mispredicts, the predictor
            // still gets one clear right after reset.
            GHRreset_o    <= (GHR_RESET_ON_MISPREDICT == 0);
        end else begin
            mispredict_o  <= mp_now;
            redirect_pc_o <= mp_now ? in_redirect : 32'd0;
            GHRreset_o    <= (GHR_RESET_ON_MISPREDICT != 0) && mp_now;
        end
    end

`ifdef UCSBECE154B_BP_STATS_EN
    // ---------------- statistics -----------------------------------------
    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_resolved_o   <= '0;
            stat_mispredict_o <= '0;
            stat_btbwrite_o   <= '0;
        end else begin
            if (accept && (stat_resolved_o != '1)) begin
                stat_resolved_o <= stat_resolved_o + 32'd1;
            end
            if (mispredict_o && (stat_mispredict_o != '1)) begin
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
            end
            if (BTB_we_o && (stat_btbwrite_o != '1)) begin
                stat_btbwrite_o <= stat_btbwrite_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154b_bp_update_ctrl.sv
module tb_ucsbece154b_bp_update_ctrl;

    localparam int MAXC = 1024;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        resolve_valid_i;
    logic        resolve_ready_o;
    logic [31:0] resolve_pc_i;
    logic [6:0]  resolve_op_i;
    logic        resolve_taken_i;
    logic [31:0] resolve_target_i;
    logic        resolve_predtaken_i;
    logic [31:0] resolve_predtarget_i;
    logic        resolve_btbhit_i;
    logic [4:0]  resolve_phtaddr_i;
    logic        BTB_we_o;
    logic [4:0]  BTBwriteaddress_o;
    logic [31:0] BTBwritedata_o;
    logic        PHTwe_o;
    logic [4:0]  PHTwriteaddress_o;
    logic        PHTincrement_o;
    logic        GHRreset_o;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;
`ifdef UCSBECE154B_BP_STATS_EN
    logic [31:0] stat_resolved_o;
    logic [31:0] stat_mispredict_o;
    logic [31:0] stat_btbwrite_o;
`endif

    ucsbece154b_bp_update_ctrl dut (
        .clk                  (clk),
        .reset_i              (reset_i),
        .resolve_valid_i      (resolve_valid_i),
        .resolve_ready_o      (resolve_ready_o),
        .resolve_pc_i         (resolve_pc_i),
        .resolve_op_i         (resolve_op_i),
        .resolve_taken_i      (resolve_taken_i),
        .resolve_target_i     (resolve_target_i),
        .resolve_predtaken_i  (resolve_predtaken_i),
        .resolve_predtarget_i (resolve_predtarget_i),
        .resolve_btbhit_i     (resolve_btbhit_i),
        .resolve_phtaddr_i    (resolve_phtaddr_i),
        .BTB_we_o             (BTB_we_o),
        .BTBwriteaddress_o    (BTBwriteaddress_o),
        .BTBwritedata_o       (BTBwritedata_o),
        .PHTwe_o              (PHTwe_o),
        .PHTwriteaddress_o    (PHTwriteaddress_o),
        .PHTincrement_o       (PHTincrement_o),
        .GHRreset_o           (GHRreset_o),
        .mispredict_o         (mispredict_o),
        .redirect_pc_o        (redirect_pc_o),
`ifdef UCSBECE154B_BP_STATS_EN
        .stat_resolved_o      (stat_resolved_o),
        .stat_mispredict_o    (stat_mispredict_o),
        .stat_btbwrite_o      (stat_btbwrite_o),
`endif
        .busy_o               (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Expected output schedule, indexed by cycle number.
    bit        exp_btb_we   [MAXC];
    bit [4:0]  exp_btb_addr [MAXC];
    bit [31:0] exp_btb_data [MAXC];
    bit        exp_pht_we   [MAXC];
    bit [4:0]  exp_pht_addr [MAXC];
    bit        exp_pht_inc  [MAXC];
    bit        exp_mp       [MAXC];
    bit [31:0] exp_redir    [MAXC];
    int        occ          [MAXC];
    int        last_pop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Each accepted resolution occupies the queue from the cycle after accept
    // until the cycle of its last write; writes are serialized in FIFO order.
    task automatic model_accept(input int n);
        logic is_br, is_j, is_ctl, tk, tgt_wrong, mp, need_btb, need_pht;
        int t, c;
        is_br     = (resolve_op_i == OP_BR);
        is_j      = (resolve_op_i == OP_JAL) || (resolve_op_i == OP_JALR);
        is_ctl    = is_br || is_j;
        tk        = is_j ? 1'b1 : resolve_taken_i;
        tgt_wrong = (resolve_predtarget_i != resolve_target_i);
        mp        = is_ctl && ((tk != resolve_predtaken_i) || (tk && tgt_wrong));
        need_btb  = is_ctl && tk && (!resolve_btbhit_i || tgt_wrong);
        need_pht  = is_br;
        if (mp) begin
            exp_mp[n+1]    = 1'b1;
            exp_redir[n+1] = tk ? resolve_target_i : resolve_pc_i + 32'd4;
        end
        t = (n + 1 > last_pop + 1) ? n + 1 : last_pop + 1;
        c = t;
        if (need_btb) begin
            c++;
            exp_btb_we[c]   = 1'b1;
            exp_btb_addr[c] = resolve_pc_i[6:2];
            exp_btb_data[c] = resolve_target_i;
        end
        if (need_pht) begin
            c++;
            exp_pht_we[c]   = 1'b1;
            exp_pht_addr[c] = resolve_phtaddr_i;
            exp_pht_inc[c]  = tk;
        end
        for (int k = n + 1; k <= c; k++) occ[k]++;
        last_pop = c;
    endtask

    task automatic model_reset(input int r);
        for (int k = r + 1; k < MAXC; k++) begin
            exp_btb_we[k] = 0; exp_btb_addr[k] = 0; exp_btb_data[k] = 0;
            exp_pht_we[k] = 0; exp_pht_addr[k] = 0; exp_pht_inc[k] = 0;
            exp_mp[k] = 0; exp_redir[k] = 0; occ[k] = 0;
        end
        last_pop = r;
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset_i) model_reset(cyc);
        else if (resolve_valid_i && occ[cyc] < 4) model_accept(cyc);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drv(input logic v, input logic [6:0] op, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk, input logic ptk,
                       input logic [31:0] ptgt, input logic hit, input logic [4:0] pa);
        resolve_valid_i      = v;
        resolve_op_i         = op;
        resolve_pc_i         = pc;
        resolve_target_i     = tgt;
        resolve_taken_i      = tk;
        resolve_predtaken_i  = ptk;
        resolve_predtarget_i = ptgt;
        resolve_btbhit_i     = hit;
        resolve_phtaddr_i    = pa;
    endtask

    task automatic idle(input int n);
        drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Compare process: every cycle against the model schedule.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("ready",     {31'd0, resolve_ready_o},   {31'd0, occ[cyc] < 4});
            chk("busy",      {31'd0, busy_o},            {31'd0, occ[cyc] > 0});
            chk("btb_we",    {31'd0, BTB_we_o},          {31'd0, exp_btb_we[cyc]});
            chk("btb_addr",  {27'd0, BTBwriteaddress_o}, {27'd0, exp_btb_addr[cyc]});
            chk("btb_data",  BTBwritedata_o,             exp_btb_data[cyc]);
            chk("pht_we",    {31'd0, PHTwe_o},           {31'd0, exp_pht_we[cyc]});
            chk("pht_addr",  {27'd0, PHTwriteaddress_o}, {27'd0, exp_pht_addr[cyc]});
            chk("pht_inc",   {31'd0, PHTincrement_o},    {31'd0, exp_pht_inc[cyc]});
            chk("mispred",   {31'd0, mispredict_o},      {31'd0, exp_mp[cyc]});
            chk("redirect",  redirect_pc_o,              exp_redir[cyc]);
            chk("ghr_reset", {31'd0, GHRreset_o},        {31'd0, exp_mp[cyc]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int acc;
        int guard;
        bit rdy_hist [16];

        reset_i = 1'b1;
        idle(3);
        reset_i = 1'b0;
        chk_en  = 1'b1;
        chk("lit_reset_ready", {31'd0, resolve_ready_o}, 32'd1);
        chk("lit_reset_busy",  {31'd0, busy_o},          32'd0);
        chk("lit_reset_btbwe", {31'd0, BTB_we_o},        32'd0);
        idle(2);

        // BTB-missed taken branch
        drv(1, OP_BR, 32'h40, 32'h80, 1, 0, 32'h0, 0, 5'd5);
        tick(); idle(0); drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        chk("lit_s1_mp",    {31'd0, mispredict_o}, 32'd1);
        chk("lit_s1_redir", redirect_pc_o,          32'h80);
        chk("lit_s1_ghr",   {31'd0, GHRreset_o},   32'd1);
        tick();
        chk("lit_s1_btbwe",   {31'd0, BTB_we_o},        32'd1);
        chk("lit_s1_btbaddr", {27'd0, BTBwriteaddress_o}, 32'd16);
        chk("lit_s1_btbdata", BTBwritedata_o,            32'h80);
        tick();
        chk("lit_s1_phtwe",   {31'd0, PHTwe_o},           32'd1);
        chk("lit_s1_phtaddr", {27'd0, PHTwriteaddress_o}, 32'd5);
        chk("lit_s1_phtinc",  {31'd0, PHTincrement_o},    32'd1);
        idle(3);

        // Correctly predicted not-taken branch
        drv(1, OP_BR, 32'h10, 32'h50, 0, 0, 32'h0, 0, 5'd3);
        tick(); drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        chk("lit_s2_mp", {31'd0, mispredict_o}, 32'd0);
        tick();
        chk("lit_s2_phtwe",  {31'd0, PHTwe_o},        32'd1);
        chk("lit_s2_phtinc", {31'd0, PHTincrement_o}, 32'd0);
        chk("lit_s2_btbwe",  {31'd0, BTB_we_o},       32'd0);
        idle(3);

        // jal, correctly predicted with BTB hit; taken input low is overridden
        drv(1, OP_JAL, 32'h20, 32'h100, 0, 1, 32'h100, 1, 5'd0);
        tick(); drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        chk("lit_jal_mp",   {31'd0, mispredict_o}, 32'd0);
        chk("lit_jal_busy", {31'd0, busy_o},       32'd1);
        tick();
        chk("lit_jal_busy2", {31'd0, busy_o},   32'd0);
        chk("lit_jal_btbwe", {31'd0, BTB_we_o}, 32'd0);
        idle(2);

        // jalr with wrong predicted target
        drv(1, OP_JALR, 32'h60, 32'h300, 1, 1, 32'h200, 1, 5'd0);
        tick(); drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        chk("lit_jalr_mp",    {31'd0, mispredict_o}, 32'd1);
        chk("lit_jalr_redir", redirect_pc_o,          32'h300);
        tick();
        chk("lit_jalr_btbwe",   {31'd0, BTB_we_o},          32'd1);
        chk("lit_jalr_btbaddr", {27'd0, BTBwriteaddress_o}, 32'd24);
        chk("lit_jalr_btbdata", BTBwritedata_o,             32'h300);
        tick();
        chk("lit_jalr_phtwe", {31'd0, PHTwe_o}, 32'd0);
        idle(2);

        // Not-taken branch predicted taken, then a non-control op
        drv(1, OP_BR, 32'h84, 32'h500, 0, 1, 32'h500, 1, 5'd7);
        tick();
        chk("lit_nt_redir", redirect_pc_o, 32'h88);
        drv(1, OP_ALU, 32'h88, 32'h900, 1, 0, 32'h0, 0, 5'd9);
        tick(); drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        chk("lit_alu_mp", {31'd0, mispredict_o}, 32'd0);
        idle(4);

        // Back-to-back branches that each need BTB and PHT writes
        acc = 0; guard = 0; n0 = cyc;
        while (acc < 6 && guard < 40) begin
            drv(1, OP_BR, 32'h100 + 32'(4 * acc), 32'h400 + 32'(16 * acc), 1, 1,
                32'h400 + 32'(16 * acc), 0, 5'(acc + 8));
            if (cyc - n0 < 16) rdy_hist[cyc - n0] = resolve_ready_o;
            if (occ[cyc] < 4) acc++;
            tick();
            guard++;
        end
        drv(0, 7'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 5'd0);
        chk("b2b_accepts", 32'(acc), 32'd6);
        chk("lit_b2b_ready4", {31'd0, rdy_hist[4]}, 32'd1);
        chk("lit_b2b_ready5", {31'd0, rdy_hist[5]}, 32'd0);
        chk("lit_b2b_ready6", {31'd0, rdy_hist[6]}, 32'd0);
        chk("lit_b2b_ready7", {31'd0, rdy_hist[7]}, 32'd1);
        idle(22);
        chk("lit_b2b_drained", {31'd0, busy_o}, 32'd0);

        // Reset while in BTB_WR with three entries queued
        n0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drv(1, OP_BR, 32'h200 + 32'(4 * i), 32'h600 + 32'(16 * i), 1, 1,
                32'h600 + 32'(16 * i), 0, 5'(i + 20));
            tick();
        end
        idle(1);
        chk("lit_rst_in_btbwr", {31'd0, BTB_we_o}, 32'd1);
        chk("lit_rst_cycle", 32'(cyc - n0), 32'd5);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("lit_rst_btbwe", {31'd0, BTB_we_o},        32'd0);
        chk("lit_rst_phtwe", {31'd0, PHTwe_o},         32'd0);
        chk("lit_rst_busy",  {31'd0, busy_o},          32'd0);
        chk("lit_rst_ready", {31'd0, resolve_ready_o}, 32'd1);
        idle(12);

        // A fresh entry after the flush still drains normally
        drv(1, OP_BR, 32'h44, 32'h88, 1, 0, 32'h0, 0, 5'd2);
        tick(); idle(5);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
